floating_point_coef_seq: RTL and testbench
==========================================

FLOATING_POINT_COEF_SEQ -- requirements
Module: floating_point_coef_seq

Interface
REQ-001 SHALL have parameter EXP_WIDTH, default 8, exponent width of the attached coefficient ROM word.
REQ-002 SHALL have parameter MAN_WIDTH, default 23, mantissa width of the attached coefficient ROM word.
REQ-003 SHALL have parameter NUM_COEF, default 7, polynomial coefficient count, legal 1..7, fetched from ROM addresses 0..NUM_COEF-1.
REQ-004 SHALL have one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-005 clk  input  1  rising-edge clock shared with the ROM.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 in_valid  input  1  operand class available.
REQ-008 in_ready  output  1  sequencer accepts a new operand.
REQ-009 in_class  input  2  operand class: 00 normal, 01 zero, 10 inf, 11 NaN.
REQ-010 rom_rd_addr  output  4  combinational address to ROM (ROM dout is registered, 1-cycle latency).
REQ-011 coef_valid  output  1  ROM dout holds the coefficient tagged by coef_idx.
REQ-012 coef_ready  input  1  consumer accepts the coefficient.
REQ-013 coef_idx  output  4  ROM address whose data is on dout.
REQ-014 coef_first / coef_last  output  1 each  first / final coefficient of the current operand.
REQ-015 coef_special  output  1  current beat is a special-case result word, not a coefficient.
REQ-016 busy  output  1  high whenever state is not IDLE.

Function
REQ-017 SHALL implement states IDLE, RUN, SPEC; in_ready=1 only in IDLE.
REQ-018 Accept = in_valid & in_ready; in the accept cycle rom_rd_addr SHALL equal the start address (normal 0; zero 8; NaN 9; inf 7), else 0 in IDLE.
REQ-019 On accept, normal SHALL go RUN and special SHALL go SPEC; coef_valid SHALL rise the following cycle with coef_first=1.
REQ-020 Registered idx_q SHALL capture rom_rd_addr every cycle; coef_idx=idx_q.
REQ-021 In RUN, rom_rd_addr SHALL be idx_q+1 when coef_valid & coef_ready & idx_q<NUM_COEF-1, else idx_q (stall holds ROM dout stable).
REQ-022 coef_last SHALL be 1 when idx_q==NUM_COEF-1 in RUN, and always in SPEC; SPEC SHALL emit exactly one beat with coef_special=1.
REQ-023 Transfer of the last beat SHALL return to IDLE; coef_valid SHALL be 0 the next cycle.
REQ-024 Unstalled latency: accept at cycle t, beat k at t+1+k, in_ready high again at t+NUM_COEF+1.
REQ-025 in_valid coinciding with a last transfer SHALL NOT be accepted (in_ready=0 that cycle).
REQ-026 coef_valid SHALL not drop, and coef_idx/coef_first/coef_last SHALL not change, while coef_ready=0.

Reset
REQ-027 rst SHALL force IDLE, coef_valid=0, idx_q=0, coef_first/last/special=0, busy=0, in_ready=1, rom_rd_addr=0, regardless of state.
REQ-028 Reset mid-sequence SHALL abandon the operand; no further beats SHALL be emitted for it.

Configuration
REQ-029 Macro FLT_COEF_SEQ_SPECIAL_EN defined: in_class decoding and SPEC state SHALL be present as above.
REQ-030 Macro undefined: in_class SHALL be ignored, every accept SHALL run the normal RUN sequence, coef_special SHALL be tied 0.

Structure
REQ-031 Package flt_coef_seq_pkg SHALL hold the state enum, in_class encodings, and ROM address constants (ADDR_INF_RESULT=7, ADDR_ZERO_RESULT=8, ADDR_NAN_RESULT=9).
REQ-032 No sub-module; the coefficient ROM SHALL stay external so the sequencer and ROM are paired at the datapath level.

Verification (EXP_WIDTH=8, MAN_WIDTH=23, NUM_COEF=7, ROM attached)
REQ-033 Normal, coef_ready=1 -> 7 beats on consecutive cycles, idx 0..6, dout e2f784c5 first, 793069f2 last with coef_last=1.
REQ-034 Zero class -> single beat, idx 8, dout 7f800000, coef_special=1, coef_first=coef_last=1.
REQ-035 NaN class -> single beat, idx 9, dout 7fc00000; inf class -> idx 7, dout 00000000.
REQ-036 Normal, coef_ready=0 for 3 cycles at idx 1 -> idx 1, dout d513d2aa held, no skipped/duplicated beat after release.
REQ-037 rst at idx 3 -> next cycle coef_valid=0, busy=0, in_ready=1; a following normal operand restarts at idx 0.
REQ-038 Macro undefined, zero class -> full 7-beat normal sequence, coef_special=0.

Source files
------------

// File: rtl/flt_coef_seq_pkg.sv
// Shared types and constants for the floating-point coefficient sequencer.
// Holds the FSM state enum, operand class codes and ROM address map.
package flt_coef_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_SPEC = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CLS_NORMAL = 2'b00,
        CLS_ZERO   = 2'b01,
        CLS_INF    = 2'b10,
        CLS_NAN    = 2'b11
    } in_class_t;

    localparam logic [3:0] ADDR_COEF_BASE   = 4'd0;
    localparam logic [3:0] ADDR_INF_RESULT  = 4'd7;
    localparam logic [3:0] ADDR_ZERO_RESULT = 4'd8;
    localparam logic [3:0] ADDR_NAN_RESULT  = 4'd9;

    // First ROM address to fetch for a given operand class
    function automatic logic [3:0] start_addr(input logic [1:0] cls);
        logic [3:0] a;
        unique case (cls)
            CLS_NORMAL: a = ADDR_COEF_BASE;
            CLS_ZERO:   a = ADDR_ZERO_RESULT;
            CLS_INF:    a = ADDR_INF_RESULT;
            CLS_NAN:    a = ADDR_NAN_RESULT;
            default:    a = ADDR_COEF_BASE;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/floating_point_coef_seq.sv
// Coefficient fetch sequencer driving an external registered-output ROM.
// FLT_COEF_SEQ_SPECIAL_EN enables class decoding and the special-result beat.
module floating_point_coef_seq
    import flt_coef_seq_pkg::*;
#(
    parameter int EXP_WIDTH = 8,
    parameter int MAN_WIDTH = 23,
    parameter int NUM_COEF  = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] in_class,
    output logic [3:0] rom_rd_addr,
    output logic       coef_valid,
    input  logic       coef_ready,
    output logic [3:0] coef_idx,
    output logic       coef_first,
    output logic       coef_last,
    output logic       coef_special,
    output logic       busy
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_COEF - 1);
    localparam int word_width_unused = 1 + EXP_WIDTH + MAN_WIDTH;

    state_t     state_q;
    state_t     state_d;
    logic [3:0] idx_q;
    logic [3:0] start_w;
    logic       spec_start;
    logic       accept;
    logic       xfer;
    logic       last_beat;

`ifdef FLT_COEF_SEQ_SPECIAL_EN
    assign start_w    = start_addr(in_class);
    assign spec_start = (in_class != CLS_NORMAL);
`else
    logic class_unused;
    assign class_unused = ^in_class;
    assign start_w      = ADDR_COEF_BASE;
    assign spec_start   = 1'b0;
`endif

    assign in_ready  = rst | (state_q == ST_IDLE);
    assign accept    = in_valid & in_ready & ~rst;
    assign xfer      = coef_valid & coef_ready;
    assign last_beat = (state_q == ST_SPEC) |
                       ((state_q == ST_RUN) & (idx_q == LAST_IDX));
    assign coef_idx  = idx_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Index register tracks the address whose data the ROM now presents
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= 4'd0;
        end else begin
            idx_q <= rom_rd_addr;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = spec_start ? ST_SPEC : ST_RUN;
                end
            end
            ST_RUN, ST_SPEC: begin
                if (xfer && last_beat) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs and ROM address; a stall re-presents idx_q so dout holds
    always_comb begin
        rom_rd_addr  = 4'd0;
        coef_valid   = 1'b0;
        coef_first   = 1'b0;
        coef_last    = 1'b0;
        coef_special = 1'b0;
        busy         = 1'b0;
        if (!rst) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        rom_rd_addr = start_w;
                    end
                end
                ST_RUN: begin
                    coef_valid = 1'b1;
                    busy       = 1'b1;
                    coef_first = (idx_q == ADDR_COEF_BASE);
                    coef_last  = (idx_q == LAST_IDX);
                    if (coef_ready && (idx_q < LAST_IDX)) begin
                        rom_rd_addr = idx_q + 4'd1;
                    end else begin
                        rom_rd_addr = idx_q;
                    end
                end
                ST_SPEC: begin
                    coef_valid  = 1'b1;
                    busy        = 1'b1;
                    coef_first  = 1'b1;
                    coef_last   = 1'b1;
`ifdef FLT_COEF_SEQ_SPECIAL_EN
                    coef_special = 1'b1;
`endif
                    rom_rd_addr = idx_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_floating_point_coef_seq.sv
// Scoreboard bench for floating_point_coef_seq with a behavioural ROM.
// Honors FLT_COEF_SEQ_SPECIAL_EN when choosing expected sequences.
module tb_floating_point_coef_seq;

    localparam int N = 7;

    typedef struct packed {
        logic [3:0]  idx;
        logic [31:0] dout;
        logic        first;
        logic        last;
        logic        special;
    } beat_t;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_class;
    logic [3:0] rom_rd_addr;
    logic       coef_valid;
    logic       coef_ready;
    logic [3:0] coef_idx;
    logic       coef_first;
    logic       coef_last;
    logic       coef_special;
    logic       busy;

    logic [31:0] rom [16];
    logic [31:0] dout;

    beat_t exp_q[$];
    int    n_chk;
    int    n_pass;
    int    rdy_mode;

    floating_point_coef_seq #(
        .EXP_WIDTH(8),
        .MAN_WIDTH(23),
        .NUM_COEF(N)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_class(in_class),
        .rom_rd_addr(rom_rd_addr),
        .coef_valid(coef_valid),
        .coef_ready(coef_ready),
        .coef_idx(coef_idx),
        .coef_first(coef_first),
        .coef_last(coef_last),
        .coef_special(coef_special),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = 32'h0;
        rom[0] = 32'he2f784c5;
        rom[1] = 32'hd513d2aa;
        rom[2] = 32'h3f8a1b2c;
        rom[3] = 32'hbc4d5e6f;
        rom[4] = 32'h3e112233;
        rom[5] = 32'hc0a0b0c0;
        rom[6] = 32'h793069f2;
        rom[7] = 32'h00000000;
        rom[8] = 32'h7f800000;
        rom[9] = 32'h7fc00000;
    end

    always @(posedge clk) dout <= rom[rom_rd_addr];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic bit is_special(input logic [1:0] cls);
`ifdef FLT_COEF_SEQ_SPECIAL_EN
        return cls != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [3:0] exp_start(input logic [1:0] cls);
        if (!is_special(cls)) return 4'd0;
        if (cls == 2'b01) return 4'd8;
        if (cls == 2'b10) return 4'd7;
        return 4'd9;
    endfunction

    task automatic push_op(input logic [1:0] cls);
        beat_t b;
        if (is_special(cls)) begin
            b.idx = exp_start(cls);
            b.dout = rom[b.idx];
            b.first = 1'b1;
            b.last = 1'b1;
            b.special = 1'b1;
            exp_q.push_back(b);
        end else begin
            for (int k = 0; k < N; k++) begin
                b.idx = 4'(k);
                b.dout = rom[k];
                b.first = (k == 0);
                b.last = (k == N - 1);
                b.special = 1'b0;
                exp_q.push_back(b);
            end
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accept edge
    task automatic issue(input logic [1:0] cls, input bit wait_done,
                         output int lat);
        int cnt;
        lat = 0;
        in_class = cls;
        in_valid = 1'b1;
        cnt = 0;
        while (!in_ready && cnt < 500) begin
            @(posedge clk); #1;
            cnt++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 64'(in_ready), 64'(1));
            in_valid = 1'b0;
            return;
        end
        chk("start_addr", 64'(rom_rd_addr), 64'(exp_start(cls)));
        push_op(cls);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_class = 2'($urandom);
        chk("first_beat", 64'({coef_valid, coef_first}), 64'(2'b11));
        if (wait_done) begin
            lat = 1;
            while (!in_ready && lat < 500) begin
                @(posedge clk); #1;
                lat++;
            end
        end
    endtask

    // coef_ready generator
    initial begin
        forever begin
            @(posedge clk); #1;
            if (rdy_mode == 0) coef_ready = 1'b1;
            else if (rdy_mode == 1) coef_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: pops expected beats on each transfer and checks stalls
    initial begin
        bit    held;
        beat_t h;
        beat_t cur;
        beat_t e;
        held = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held = 1'b0;
            end else begin
                chk("busy_vs_valid", 64'(busy), 64'(coef_valid));
                chk("ready_vs_busy", 64'(in_ready), 64'(!busy));
                cur = '{coef_idx, dout, coef_first, coef_last, coef_special};
                if (held) begin
                    chk("stall_valid", 64'(coef_valid), 64'(1));
                    if (coef_valid) chk("stall_hold", 64'(cur), 64'(h));
                end
                if (coef_valid) begin
                    if (coef_ready) begin
                        if (exp_q.size() == 0) begin
                            chk("unexpected_beat", 64'(cur), 64'(0));
                        end else begin
                            e = exp_q.pop_front();
                            chk("beat", 64'(cur), 64'(e));
                        end
                        if (coef_last) chk("last_in_ready", 64'(in_ready), 64'(0));
                    end
                    held = !coef_ready;
                    h = cur;
                end else begin
                    held = 1'b0;
                end
            end
        end
    end

    initial begin
        int lat;
        int cnt;
        logic [1:0] cls;
        n_chk = 0;
        n_pass = 0;
        rdy_mode = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        in_class = 2'b00;
        coef_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(coef_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_addr", 64'(rom_rd_addr), 64'(0));
        chk("rst_idx", 64'(coef_idx), 64'(0));
        chk("rst_flags", 64'({coef_first, coef_last, coef_special}), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed classes, unstalled, with latency check
        for (int c = 0; c < 4; c++) begin
            cls = 2'(c);
            issue(cls, 1'b1, lat);
            chk("latency", 64'(lat), 64'(is_special(cls) ? 2 : N + 1));
        end

        // Hold ready low for three cycles while idx 1 is presented
        rdy_mode = 2;
        coef_ready = 1'b1;
        issue(2'b00, 1'b0, lat);
        @(posedge clk); #1;
        coef_ready = 1'b0;
        chk("stall_idx", 64'({coef_idx, dout}), 64'({4'd1, 32'hd513d2aa}));
        repeat (2) begin
            @(posedge clk); #1;
            chk("stall_idx", 64'({coef_idx, dout}), 64'({4'd1, 32'hd513d2aa}));
        end
        @(posedge clk); #1;
        coef_ready = 1'b1;
        cnt = 0;
        while (!in_ready && cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("stall_done", 64'(in_ready), 64'(1));
        rdy_mode = 0;

        // Reset in the middle of a normal sequence
        issue(2'b00, 1'b0, lat);
        cnt = 0;
        while (!(coef_valid && coef_idx == 4'd3) && cnt < 50) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("reach_idx3", 64'(coef_idx), 64'(3));
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(coef_valid), 64'(0));
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk); #1;
        chk("post_rst_valid", 64'(coef_valid), 64'(0));
        issue(2'b00, 1'b1, lat);
        chk("restart_latency", 64'(lat), 64'(N + 1));

        // Random classes, unstalled
        for (int i = 0; i < 8; i++) begin
            cls = 2'($urandom_range(0, 3));
            issue(cls, 1'b1, lat);
            chk("latency", 64'(lat), 64'(is_special(cls) ? 2 : N + 1));
        end

        // Random classes, random back-pressure, back-to-back requests
        rdy_mode = 1;
        for (int i = 0; i < 30; i++) begin
            cls = 2'($urandom_range(0, 3));
            issue(cls, 1'b0, lat);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        cnt = 0;
        while ((exp_q.size() != 0 || !in_ready) && cnt < 1000) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("drain", 64'(exp_q.size()), 64'(0));
        rdy_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_end", 64'({coef_valid, busy}), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
